hilo_muldiv: RTL and testbench



---
 rtl/mips_pkg.sv | 25 ++
 rtl/hilo_muldiv.sv | 159 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared decode constants and state encoding for the MIPS integer pipeline blocks.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

    // Signed variants take operand magnitudes and fix the sign at the end.
    function automatic logic is_signed_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU are ignored.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mips_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t      state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               neg_lo;
    logic               neg_hi;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic               accept;
    logic               last_step;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] result;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
`endif

    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign done      = (state == ST_FIX);
    assign accept    = start && ((state == ST_IDLE) || (state == ST_FIX));
    assign last_step = (count == CW'(WIDTH));

    always_comb begin
        rs_neg = is_signed_funct(funct) && rs_val[WIDTH-1];
        rt_neg = is_signed_funct(funct) && rt_val[WIDTH-1];
        rs_mag = rs_neg ? -rs_val : rs_val;
        rt_mag = rt_neg ? -rt_val : rt_val;
    end

    // Shift-add: the multiplier sits in the low half and drains out as the product shifts in.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    // Restoring step: remainder in the high half, dividend bits shift out of the low half
    // while quotient bits shift in behind them.
    always_comb begin
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_comb begin
        result = neg_lo ? -acc : acc;
`ifdef MULDIV_DIV_EN
        if (state == ST_DIV) begin
            result[2*WIDTH-1:WIDTH] = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            result[WIDTH-1:0]       = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
`endif
    end

    // The sign fix-up and HI/LO write happen on the edge that enters FIX, so FIX is the done cycle
    // and can accept the next command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FIX: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        if ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU)) begin
                            acc     <= {{WIDTH{1'b0}}, rt_mag};
                            operand <= rs_mag;
                            neg_lo  <= rs_neg ^ rt_neg;
                            neg_hi  <= 1'b0;
                            count   <= '0;
                            state   <= ST_MUL;
`ifdef MULDIV_DIV_EN
                        end else if ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU)) begin
                            state <= ST_DIV;
                            if (rt_val == '0) begin
                                // Divide by zero skips iteration: the forced result waits in acc unsigned.
                                acc     <= {rs_val, {WIDTH{1'b1}}};
                                operand <= '0;
                                neg_lo  <= 1'b0;
                                neg_hi  <= 1'b0;
                                count   <= CW'(WIDTH);
                            end else begin
                                acc     <= {{WIDTH{1'b0}}, rs_mag};
                                operand <= rt_mag;
                                neg_lo  <= rs_neg ^ rt_neg;
                                neg_hi  <= rs_neg;
                                count   <= '0;
                            end
`endif
                        end else if (funct == FUNCT_MTHI) begin
                            hi <= rs_val;
                        end else if (funct == FUNCT_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                ST_MUL: begin
                    if (last_step) begin
                        hi    <= result[2*WIDTH-1:WIDTH];
                        lo    <= result[WIDTH-1:0];
                        state <= ST_FIX;
                    end else begin
                        acc   <= mul_next;
                        count <= count + CW'(1);
                    end
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    if (last_step) begin
                        hi    <= result[2*WIDTH-1:WIDTH];
                        lo    <= result[WIDTH-1:0];
                        state <= ST_FIX;
                    end else begin
                        acc   <= div_next;
                        count <= count + CW'(1);
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed commands push expected HI/LO and done cycle,
// a monitor pops and compares on every done pulse. Divider cases need MULDIV_DIV_EN.
module tb_hilo_muldiv;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t expQ[$];
    int   cycle;
    int   checks;
    int   fails;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .funct(funct),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives a command so that the next rising edge samples it; returns that edge's cycle number.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                 output int c0);
        start  = 1'b1;
        funct  = f;
        rs_val = rs;
        rt_val = rt;
        @(posedge clk);
        #1;
        c0     = cycle;
        start  = 1'b0;
        funct  = 6'h00;
    endtask

    task automatic runOp(input string name, input logic [5:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input int busyExp);
        int c0;
        int nBusy;
        bit seen;
        applyStimulus(f, rs, rt, c0);
        expQ.push_back('{hi: eh, lo: el, cyc: c0 + lat, name: name});
        nBusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nBusy++;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s_timeout: got no done, expected done within 200 cycles", name);
        end else begin
            checkOutput({name, "_busy_cycles"}, 64'(nBusy), 64'(busyExp));
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cycle);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                checkOutput({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                checkOutput({e.name, "_done_cycle"}, 64'(cycle), 64'(e.cyc));
            end
        end
    end

    initial begin
        int c;
        cycle  = 0;
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        funct  = 6'h00;
        rs_val = '0;
        rt_val = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi", 64'(hi), 64'h0);
        checkOutput("reset_lo", 64'(lo), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        checkOutput("reset_done", 64'(done), 64'h0);

        runOp("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 33);
        @(negedge clk);
        checkOutput("mult_done_one_cycle", 64'(done), 64'h0);

        runOp("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 33);
        applyStimulus(F_MTLO, 32'h0000_1234, 32'h0, c);
        @(negedge clk);
        checkOutput("mtlo_lo", 64'(lo), 64'h1234);
        checkOutput("mtlo_hi_kept", 64'(hi), 64'hFFFF_FFFE);
        checkOutput("mtlo_busy", 64'(busy), 64'h0);
        checkOutput("mtlo_done", 64'(done), 64'h0);
        applyStimulus(F_MTHI, 32'h0000_CAFE, 32'h0, c);
        @(negedge clk);
        checkOutput("mthi_hi", 64'(hi), 64'hCAFE);
        checkOutput("mthi_lo_kept", 64'(lo), 64'h1234);

        applyStimulus(6'h20, 32'h5555_5555, 32'h3, c);
        @(negedge clk);
        checkOutput("unknown_busy", 64'(busy), 64'h0);
        @(negedge clk);
        checkOutput("unknown_hi", 64'(hi), 64'hCAFE);
        checkOutput("unknown_lo", 64'(lo), 64'h1234);

`ifdef MULDIV_DIV_EN
        runOp("div_neg7by2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33);
        runOp("div_minby_neg1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 33);
        runOp("divu_by0", F_DIVU, 32'd10, 32'd0, 32'd10, 32'hFFFF_FFFF, 1, 1);
        runOp("divu_100by7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33);
        runOp("div_neg100by0", F_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1, 1);
`else
        applyStimulus(F_DIV, 32'd100, 32'd7, c);
        @(negedge clk);
        checkOutput("div_disabled_busy", 64'(busy), 64'h0);
        applyStimulus(F_DIVU, 32'd10, 32'd0, c);
        @(negedge clk);
        checkOutput("divu_disabled_busy", 64'(busy), 64'h0);
        @(negedge clk);
        checkOutput("div_disabled_done", 64'(done), 64'h0);
        checkOutput("div_disabled_hi", 64'(hi), 64'hCAFE);
        checkOutput("div_disabled_lo", 64'(lo), 64'h1234);
`endif

        runOp("b2b_multu_5x6", F_MULTU, 32'd5, 32'd6, 32'h0, 32'd30, 33, 33);
        runOp("b2b_mult_2xneg3", F_MULT, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33, 33);
        runOp("mult_min_sq", F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, 33);
        runOp("mult_neg1x5", F_MULT, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 33, 33);

        // Aborted multiply: a start while busy is ignored, then reset clears everything.
        applyStimulus(F_MULT, 32'h1111_1111, 32'd3, c);
        repeat (5) @(negedge clk);
        applyStimulus(F_MTHI, 32'h0000_DEAD, 32'h0, c);
        @(negedge clk);
        checkOutput("busy_start_hi_kept", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("busy_start_lo_kept", 64'(lo), 64'hFFFF_FFFB);
        checkOutput("busy_start_busy", 64'(busy), 64'h1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midop_reset_hi", 64'(hi), 64'h0);
        checkOutput("midop_reset_lo", 64'(lo), 64'h0);
        checkOutput("midop_reset_busy", 64'(busy), 64'h0);
        checkOutput("midop_reset_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_busy", 64'(busy), 64'h0);

        runOp("mult_3x4", F_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 33, 33);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
